plru_ctrl: RTL and testbench
============================

# plru_ctrl

Four-way tree pseudo-LRU replacement controller for the cache datapath. Sits upstream of the per-set replacement state: the cache FSM presents each access (set index, hit/miss, hit way), and the block returns the way to use. That is the hit way on a hit, or the PLRU victim on a miss. It then writes back the updated tree bits. It holds one 3-bit tree per set in internal flops and serialises accesses through a small read-modify-write state machine.

## Interface
- NUM_SETS, 16, number of sets; power of two, ≥2
- SET_W, $clog2(NUM_SETS), set index width (derived)

- clk  in  1  clock, all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- req_valid  in  1  access request
- req_ready  out  1  block can accept a request this cycle
- req_set  in  SET_W  set index of access
- req_hit  in  1  1 = hit, 0 = miss
- req_way  in  2  hit way; ignored when req_hit=0
- resp_valid  out  1  one-cycle pulse, resp_way valid
- resp_way  out  2  way used (hit way or victim)
- hit_count  out  16  saturating hit counter (see Configuration)
- miss_count  out  16  saturating miss counter (see Configuration)

## Operation
- Tree bits per set, {b2,b1,b0}:
  - b0: 0 → victim in ways 0/1; 1 → victim in ways 2/3.
  - b1: 0 → way0; 1 → way1.
  - b2: 0 → way2; 1 → way3.
- Touch rule, applied to the way used; untouched bits are kept:
  - way0: b0=1, b1=1
  - way1: b0=1, b1=0
  - way2: b0=0, b2=1
  - way3: b0=0, b2=0
- Used way is req_way if req_hit=1, otherwise the victim decoded from the current bits.
- FSM states IDLE → READ → WRITE → IDLE:
  - IDLE: req_ready=1. A request is accepted when req_valid & req_ready at the edge. The block registers set, hit and way, then moves to READ.
  - READ: latch the selected set's tree bits; compute used way and next bits.
  - WRITE: write next bits to the set; drive resp_valid=1 and resp_way; return to IDLE.
- req_ready=0 in READ and WRITE. req_valid is ignored in those states; the requester must hold the request.
- Only one access is in flight, so there are no read/write hazards between consecutive accesses to the same set.
- Reset, asynchronous:
  - All tree bits are cleared to 000, giving victim way0 for every set.
  - FSM goes to IDLE and resp_valid=0.
  - Any in-flight request is dropped, with no writeback and no response.

## Timing
- Reset values:
  - req_ready=1
  - resp_valid=0
  - resp_way=00
  - hit_count=0
  - miss_count=0
- Latency: request accepted at edge N; resp_valid high during cycle N+2, i.e. sampled at edge N+3.
- Throughput: one access per 3 cycles. req_ready rises in the cycle after WRITE.
- resp_way is registered and holds its last value when resp_valid=0.
- The updated tree bits are visible to a request accepted at or after the edge that ends WRITE.

## Configuration
- PLRU_PERF_EN defined:
  - hit_count increments on each WRITE with registered hit=1.
  - miss_count increments on each WRITE with registered hit=0.
  - Both saturate at 16'hFFFF and clear on rst.
- PLRU_PERF_EN undefined: the counter flops are not built, and both ports are tied to 0.

## Structure
- Shared package plru_pkg holds:
  - typedef plru_bits_t (logic [2:0]);
  - typedef way_t (logic [1:0]);
  - FSM state enum {IDLE, READ, WRITE};
  - reset constant PLRU_RESET = 3'b000.
- Sub-module plru_tree: purely combinational (bits, hit, hit_way) → (used_way, next_bits). It is shared with any future per-set replacement logic.
- Top module plru_ctrl holds the FSM, the NUM_SETS×3 tree array, the response registers and the optional counters.

## Test plan
- Reset → req_ready=1, resp_valid=0, resp_way=00; a miss on set 0 returns way0.
- Five back-to-back misses on set 3 from reset → resp_way sequence 0, 2, 1, 3, 0.
- Hit on set 5 way2, then miss on set 5 → first resp_way=2 (bits become 100), miss victim=way0.
- Miss on set 1 (victim 0), then miss on set 2 → set 2 victim=way0; sets are independent.
- Request held during READ/WRITE with a changed req_set → ignored. resp_valid arrives exactly 2 cycles after acceptance, then req_ready=1.
- rst asserted in READ after a miss on set 7 → no resp_valid; the next miss on set 7 returns way0. With PLRU_PERF_EN: 3 hits + 2 misses → hit_count=3, miss_count=2.

Source files
------------

// File: rtl/plru_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : plru_pkg
//  Description : Shared types and constants for the 4-way tree pseudo-LRU
//                replacement logic (tree bits, way index, controller states).
//  Revision    : 1.0 - initial release
// ============================================================================
package plru_pkg;

    // Tree bits {b2,b1,b0}: b0 picks the half, b1/b2 pick within each half
    typedef logic [2:0] plru_bits_t;

    // Way index within a set
    typedef logic [1:0] way_t;

    // Read-modify-write controller states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2
    } state_t;

    // Tree value after reset: victim is way0
    localparam plru_bits_t PLRU_RESET = 3'b000;

endpackage
`default_nettype wire

// File: rtl/plru_tree.sv
`default_nettype none
// ============================================================================
//  Module      : plru_tree
//  Description : Combinational 4-way tree PLRU update. Picks the used way
//                (hit way, or the victim on a miss) and returns the tree bits
//                after touching that way.
//  Revision    : 1.0 - initial release
// ============================================================================
module plru_tree
    import plru_pkg::*;
(
    input  plru_bits_t bits,
    input  logic       hit,
    input  way_t       hit_way,
    output way_t       used_way,
    output plru_bits_t next_bits
);

    way_t w_victim;

    // Decode victim, choose the used way, then point the tree away from it
    always_comb begin
        // b0 selects the half; b2 resolves ways 2/3, b1 resolves ways 0/1
        w_victim  = bits[0] ? {1'b1, bits[2]} : {1'b0, bits[1]};
        used_way  = hit ? hit_way : w_victim;
        next_bits = bits;
        // Point the root at the other half
        next_bits[0] = ~used_way[1];
        // Point the leaf of the touched half at the sibling way
        if (used_way[1]) begin
            next_bits[2] = ~used_way[0];
        end else begin
            next_bits[1] = ~used_way[0];
        end
    end

endmodule
`default_nettype wire

// File: rtl/plru_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : plru_ctrl
//  Description : Four-way tree pseudo-LRU replacement controller. Holds one
//                3-bit tree per set and serialises accesses through an
//                IDLE -> READ -> WRITE read-modify-write sequence, returning
//                the used way (hit way or victim) with a one-cycle pulse.
//                Optional hit/miss counters are built when PLRU_PERF_EN is
//                defined; otherwise both count ports are tied to zero.
//  Revision    : 1.0 - initial release
// ============================================================================
module plru_ctrl
    import plru_pkg::*;
#(
    parameter int NUM_SETS = 16,
    parameter int SET_W    = $clog2(NUM_SETS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [SET_W-1:0] req_set,
    input  logic             req_hit,
    input  logic [1:0]       req_way,
    output logic             resp_valid,
    output logic [1:0]       resp_way,
    output logic [15:0]      hit_count,
    output logic [15:0]      miss_count
);

    state_t           r_state;
    state_t           w_next_state;

    plru_bits_t       r_tree [NUM_SETS];
    logic [SET_W-1:0] r_set;
    logic             r_hit;
    way_t             r_way;
    plru_bits_t       r_bits;

    way_t             w_used_way;
    plru_bits_t       w_next_bits;

    // Update rule applied to the tree bits latched in READ
    plru_tree u_tree (
        .bits      (r_bits),
        .hit       (r_hit),
        .hit_way   (r_way),
        .used_way  (w_used_way),
        .next_bits (w_next_bits)
    );

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state and ready decode; requests are only seen in IDLE
    always_comb begin
        w_next_state = r_state;
        req_ready    = 1'b0;
        case (r_state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    w_next_state = READ;
                end
            end
            READ:    w_next_state = WRITE;
            WRITE:   w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // Request capture, tree read in READ, response registers loaded in WRITE
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_set      <= '0;
            r_hit      <= 1'b0;
            r_way      <= '0;
            r_bits     <= PLRU_RESET;
            resp_valid <= 1'b0;
            resp_way   <= '0;
        end else begin
            resp_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (req_valid) begin
                        r_set <= req_set;
                        r_hit <= req_hit;
                        r_way <= req_way;
                    end
                end
                READ: begin
                    r_bits <= r_tree[r_set];
                end
                WRITE: begin
                    resp_valid <= 1'b1;
                    resp_way   <= w_used_way;
                end
                default: ;
            endcase
        end
    end

    // Per-set tree storage; written back once per access in WRITE
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_SETS; i++) begin
                r_tree[i] <= PLRU_RESET;
            end
        end else if (r_state == WRITE) begin
            r_tree[r_set] <= w_next_bits;
        end
    end

`ifdef PLRU_PERF_EN
    logic [15:0] r_hit_cnt;
    logic [15:0] r_miss_cnt;

    // Saturating hit/miss counters, one step per completed access
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hit_cnt  <= '0;
            r_miss_cnt <= '0;
        end else if (r_state == WRITE) begin
            if (r_hit) begin
                if (r_hit_cnt != 16'hFFFF) begin
                    r_hit_cnt <= r_hit_cnt + 16'd1;
                end
            end else begin
                if (r_miss_cnt != 16'hFFFF) begin
                    r_miss_cnt <= r_miss_cnt + 16'd1;
                end
            end
        end
    end

    assign hit_count  = r_hit_cnt;
    assign miss_count = r_miss_cnt;
`else
    assign hit_count  = 16'd0;
    assign miss_count = 16'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_plru_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_plru_ctrl
//  Description : Self-checking bench for plru_ctrl. A driver issues directed
//                accesses and queues the hand-computed way; a monitor pops
//                and compares on every response pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_plru_ctrl;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [3:0]  req_set;
    logic        req_hit;
    logic [1:0]  req_way;
    logic        resp_valid;
    logic [1:0]  resp_way;
    logic [15:0] hit_count;
    logic [15:0] miss_count;

    int total = 0;
    int bad   = 0;
    logic [1:0] exp_q[$];

    plru_ctrl #(.NUM_SETS(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_set    (req_set),
        .req_hit    (req_hit),
        .req_way    (req_way),
        .resp_valid (resp_valid),
        .resp_way   (resp_way),
        .hit_count  (hit_count),
        .miss_count (miss_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every response pulse must match the oldest queued expectation
    always @(negedge clk) begin
        if (resp_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_resp", 32'd1, 32'd0);
            end else begin
                chk("resp_way", {30'd0, resp_way}, {30'd0, exp_q.pop_front()});
            end
        end
    end

    // Issue one access; scramble req_set while busy to show it is ignored
    task automatic issue(input logic [3:0] s, input logic h, input logic [1:0] w,
                         input logic [1:0] e);
        int waitc = 0;
        @(negedge clk);
        req_valid = 1'b1;
        req_set   = s;
        req_hit   = h;
        req_way   = w;
        while (req_ready !== 1'b1 && waitc < 20) begin
            @(negedge clk);
            waitc++;
        end
        if (req_ready !== 1'b1) begin
            chk("ready_timeout", 32'd0, 32'd1);
            req_valid = 1'b0;
            return;
        end
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        req_set = ~s;
        req_hit = ~h;
        req_way = ~w;
        chk("ready_in_read", {31'd0, req_ready}, 32'd0);
        chk("valid_in_read", {31'd0, resp_valid}, 32'd0);
        @(posedge clk);
        #1;
        chk("ready_in_write", {31'd0, req_ready}, 32'd0);
        chk("valid_in_write", {31'd0, resp_valid}, 32'd0);
        @(posedge clk);
        #1;
        chk("valid_after_write", {31'd0, resp_valid}, 32'd1);
        chk("ready_after_write", {31'd0, req_ready}, 32'd1);
        req_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] exp_hits;
        logic [15:0] exp_miss;
`ifdef PLRU_PERF_EN
        exp_hits = 16'd3;
        exp_miss = 16'd2;
`else
        exp_hits = 16'd0;
        exp_miss = 16'd0;
`endif
        rst       = 1'b1;
        req_valid = 1'b0;
        req_set   = '0;
        req_hit   = 1'b0;
        req_way   = '0;
        repeat (3) @(negedge clk);
        chk("rst_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_valid", {31'd0, resp_valid}, 32'd0);
        chk("rst_way", {30'd0, resp_way}, 32'd0);
        chk("rst_hits", {16'd0, hit_count}, 32'd0);
        chk("rst_miss", {16'd0, miss_count}, 32'd0);
        rst = 1'b0;

        // First miss on a fresh set
        issue(4'd0, 1'b0, 2'd0, 2'd0);
        // Five misses walk the tree through every way
        issue(4'd3, 1'b0, 2'd0, 2'd0);
        issue(4'd3, 1'b0, 2'd0, 2'd2);
        issue(4'd3, 1'b0, 2'd0, 2'd1);
        issue(4'd3, 1'b0, 2'd0, 2'd3);
        issue(4'd3, 1'b0, 2'd0, 2'd0);
        // Hit way2 then miss: tree 100 gives victim way0
        issue(4'd5, 1'b1, 2'd2, 2'd2);
        issue(4'd5, 1'b0, 2'd3, 2'd0);
        // Sets are independent
        issue(4'd1, 1'b0, 2'd0, 2'd0);
        issue(4'd2, 1'b0, 2'd0, 2'd0);
        // Hit way1 (001), hit way3 (000), miss -> way0
        issue(4'd9, 1'b1, 2'd1, 2'd1);
        issue(4'd9, 1'b1, 2'd3, 2'd3);
        issue(4'd9, 1'b0, 2'd2, 2'd0);

        // Reset while READ is in progress drops the access
        @(negedge clk);
        req_valid = 1'b1;
        req_set   = 4'd7;
        req_hit   = 1'b0;
        req_way   = 2'd0;
        chk("pre_abort_ready", {31'd0, req_ready}, 32'd1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        chk("abort_in_read", {31'd0, req_ready}, 32'd0);
        rst = 1'b1;
        #1;
        chk("abort_async_ready", {31'd0, req_ready}, 32'd1);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("abort_no_resp", {31'd0, resp_valid}, 32'd0);
        end
        chk("abort_hits", {16'd0, hit_count}, 32'd0);
        chk("abort_miss", {16'd0, miss_count}, 32'd0);

        // Trees cleared by reset: set 7 and the walked set 3 both start at way0
        issue(4'd7, 1'b0, 2'd0, 2'd0);
        issue(4'd3, 1'b0, 2'd0, 2'd0);
        // Three hits
        issue(4'd4, 1'b1, 2'd3, 2'd3);
        issue(4'd4, 1'b1, 2'd0, 2'd0);
        issue(4'd4, 1'b1, 2'd1, 2'd1);

        repeat (3) @(negedge clk);
        chk("hit_count", {16'd0, hit_count}, {16'd0, exp_hits});
        chk("miss_count", {16'd0, miss_count}, {16'd0, exp_miss});
        chk("hold_way", {30'd0, resp_way}, 32'd1);
        chk("queue_drained", exp_q.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
